// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift engine: shift-direction encoding, engine
// state type and the "count 0 means full width" conversion.
package pio_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_AUTO_PUSH = 1'b1
  } engine_state_e;

  // A shift count or threshold field of zero encodes the full register width.
  function automatic int unsigned count_bits(input int unsigned count, input int unsigned data_w);
    return (count == 0) ? data_w : count;
  endfunction

endpackage

// File: rtl/pio_shift_reg.sv
// One shift register with its fill counter, shared by the ISR and the OSR.
// A load and a shift in the same cycle shift the freshly loaded word.
module pio_shift_reg
  import pio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(DATA_W),
  parameter int RESET_CNT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dir,
  input  logic              shift,
  input  logic [CNT_W:0]    shift_n,
  input  logic [DATA_W-1:0] shift_src,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W:0]    cnt,
  output logic [CNT_W:0]    cnt_next,
  output logic [DATA_W-1:0] shift_out
);

  localparam logic [CNT_W:0]   FULL_CNT = (CNT_W+1)'(DATA_W);
  localparam logic [CNT_W+1:0] FULL_SUM = (CNT_W+2)'(DATA_W);

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] data_next;
  logic [CNT_W:0]    cnt_base;
  logic [CNT_W+1:0]  cnt_sum;

  always_comb begin
    base     = load ? load_data : data;
    cnt_base = load ? '0 : cnt;
    mask     = ~({DATA_W{1'b1}} << shift_n);
    src      = shift_src & mask;
    cnt_sum  = {1'b0, cnt_base} + {1'b0, shift_n};
    if (dir == DIR_RIGHT) begin
      shift_out = base & mask;
      shifted   = (base >> shift_n) | (src << (FULL_SUM - {1'b0, shift_n}));
    end else begin
      shift_out = base >> (FULL_SUM - {1'b0, shift_n});
      shifted   = (base << shift_n) | src;
    end

    data_next = data;
    cnt_next  = cnt;
    if (clear) begin
      data_next = '0;
      cnt_next  = '0;
    end else if (shift) begin
      data_next = shifted;
      cnt_next  = (cnt_sum > FULL_SUM) ? FULL_CNT : cnt_sum[CNT_W:0];
    end else if (load) begin
      data_next = load_data;
      cnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      cnt  <= (CNT_W+1)'(RESET_CNT);
    end else begin
      data <= data_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/pio_shift_engine.sv
// PIO-style ISR/OSR shift engine with FIFO push/pull handshakes.
// Define PIO_AUTO_SHIFT_EN to compile in autopush/autopull on the fill thresholds.
module pio_shift_engine
  import pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              cfg_in_right,
  input  logic              cfg_out_right,
  input  logic [CNT_W-1:0]  cfg_push_thresh,
  input  logic [CNT_W-1:0]  cfg_pull_thresh,
  input  logic              in_shift,
  input  logic [CNT_W-1:0]  in_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_shift,
  input  logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] out_data,
  input  logic              push_req,
  input  logic              pull_req,
  input  logic              blocking,
  input  logic [DATA_W-1:0] pull_fallback,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              stall,
  output logic [CNT_W:0]    isr_cnt,
  output logic [CNT_W:0]    osr_cnt,
  output logic              osr_empty,
  output engine_state_e     fsm_state
);

  // Handshakes: rx_valid/tx_ready are asserted only while a push/pull executes
  // on a penable cycle; a transfer happens when rx_valid&&rx_ready or
  // tx_ready&&tx_valid; a blocking miss raises stall and freezes all state.

  engine_state_e     state, state_next;
  logic [CNT_W:0]    in_n, out_n, pull_bits;
  logic              isr_shift, isr_clear;
  logic              osr_shift, osr_load;
  logic [DATA_W-1:0] osr_load_data;
  logic [DATA_W-1:0] isr_data, osr_data;
  logic [DATA_W-1:0] osr_shift_out;
  logic [CNT_W:0]    isr_cnt_next;
  logic [DATA_W-1:0] isr_out_unused;
  logic [CNT_W:0]    osr_cnt_next_unused;

  assign in_n      = (CNT_W+1)'(count_bits(32'(in_count), DATA_W));
  assign out_n     = (CNT_W+1)'(count_bits(32'(out_count), DATA_W));
  assign pull_bits = (CNT_W+1)'(count_bits(32'(cfg_pull_thresh), DATA_W));
  assign osr_empty = (osr_cnt >= pull_bits);
  assign rx_data   = isr_data;
  assign fsm_state = state;

`ifdef PIO_AUTO_SHIFT_EN
  logic [CNT_W:0] push_bits;
  assign push_bits = (CNT_W+1)'(count_bits(32'(cfg_push_thresh), DATA_W));
`else
  logic auto_unused;
  assign auto_unused = ^{cfg_push_thresh, isr_cnt_next, osr_data};
`endif

  pio_shift_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RESET_CNT(0)) u_isr (
    .clk       (clk),
    .reset     (reset),
    .dir       (cfg_in_right),
    .shift     (isr_shift),
    .shift_n   (in_n),
    .shift_src (in_data),
    .load      (1'b0),
    .load_data ('0),
    .clear     (isr_clear),
    .data      (isr_data),
    .cnt       (isr_cnt),
    .cnt_next  (isr_cnt_next),
    .shift_out (isr_out_unused)
  );

  pio_shift_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RESET_CNT(DATA_W)) u_osr (
    .clk       (clk),
    .reset     (reset),
    .dir       (cfg_out_right),
    .shift     (osr_shift),
    .shift_n   (out_n),
    .shift_src ('0),
    .load      (osr_load),
    .load_data (osr_load_data),
    .clear     (1'b0),
    .data      (osr_data),
    .cnt       (osr_cnt),
    .cnt_next  (osr_cnt_next_unused),
    .shift_out (osr_shift_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    rx_valid      = 1'b0;
    tx_ready      = 1'b0;
    stall         = 1'b0;
    isr_shift     = 1'b0;
    isr_clear     = 1'b0;
    osr_shift     = 1'b0;
    osr_load      = 1'b0;
    osr_load_data = tx_data;
    out_data      = '0;
    if (penable) begin
      if (state == ST_AUTO_PUSH) begin
        // Pending autopush always blocks and pre-empts every new request.
        rx_valid = 1'b1;
        if (rx_ready) begin
          isr_clear  = 1'b1;
          state_next = ST_RUN;
        end else begin
          stall = 1'b1;
        end
      end else if (push_req) begin
        rx_valid = 1'b1;
        if (rx_ready || !blocking) isr_clear = 1'b1;
        else                       stall     = 1'b1;
      end else if (pull_req) begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          osr_load = 1'b1;
        end else if (blocking) begin
          stall = 1'b1;
        end else begin
          osr_load      = 1'b1;
          osr_load_data = pull_fallback;
        end
      end else if (in_shift) begin
        isr_shift = 1'b1;
`ifdef PIO_AUTO_SHIFT_EN
        if (isr_cnt_next >= push_bits) state_next = ST_AUTO_PUSH;
`endif
      end else if (out_shift) begin
`ifdef PIO_AUTO_SHIFT_EN
        if (osr_empty) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            osr_load  = 1'b1;
            osr_shift = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end else begin
          osr_shift = 1'b1;
        end
`else
        osr_shift = 1'b1;
`endif
      end
    end
    if (osr_shift) out_data = osr_shift_out;
  end

endmodule

// File: doc/pio_shift_engine.md
PIO_SHIFT_ENGINE -- requirements
Module: pio_shift_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: ISR/OSR/FIFO data width, power of two, 8..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W): width of shift-count and threshold fields; count value 0 means DATA_W.
REQ-003 SHALL have ports: clk in 1 (the single clock); reset in 1 (synchronous, active-high).
REQ-004 SHALL have: penable in 1, divided-clock enable; no state changes while low.
REQ-005 SHALL have: cfg_in_right in 1, ISR shift direction; cfg_out_right in 1, OSR shift direction; cfg_push_thresh in CNT_W; cfg_pull_thresh in CNT_W.
REQ-006 SHALL have: in_shift in 1; in_count in CNT_W; in_data in DATA_W, source bits LSB-aligned.
REQ-007 SHALL have: out_shift in 1; out_count in CNT_W; out_data out DATA_W, shifted-out bits LSB-aligned.
REQ-008 SHALL have: push_req in 1; pull_req in 1; blocking in 1; pull_fallback in DATA_W, loaded on non-blocking pull from empty.
REQ-009 SHALL have: tx_valid in 1; tx_data in DATA_W; tx_ready out 1; rx_valid out 1; rx_data out DATA_W; rx_ready in 1.
REQ-010 SHALL have: stall out 1; isr_cnt out CNT_W+1; osr_cnt out CNT_W+1; osr_empty out 1 (osr_cnt >= cfg_pull_thresh).

Function
REQ-011 SHALL act only on cycles with penable=1; request priority push_req > pull_req > in_shift > out_shift, lower requests ignored.
REQ-012 in_shift SHALL shift n bits (n = in_count, 0 -> DATA_W): left: isr <= (isr<<n)|in_data[n-1:0]; right: isr <= (isr>>n)|(in_data[n-1:0]<<(DATA_W-n)); isr_cnt <= min(isr_cnt+n, DATA_W).
REQ-013 out_shift SHALL present n bits combinationally on out_data: right: osr[n-1:0]; left: osr[DATA_W-1:DATA_W-n]; OSR shifted by n, zero fill; osr_cnt <= min(osr_cnt+n, DATA_W).
REQ-014 Push: rx_valid=1, rx_data=isr in the same cycle; on rx_ready, isr and isr_cnt clear next edge; on !rx_ready with blocking=1, stall=1 and no state change; with blocking=0, isr/isr_cnt clear, data dropped.
REQ-015 Pull: tx_ready=1; on tx_valid, osr <= tx_data, osr_cnt <= 0; on !tx_valid with blocking=1, stall=1; with blocking=0, osr <= pull_fallback, osr_cnt <= 0.
REQ-016 rx_valid and tx_ready SHALL be low when not pushing/pulling or when penable=0; stall SHALL be combinational, low when penable=0.
REQ-017 out_data SHALL be 0 when no out_shift executes.

Reset
REQ-018 On reset, next edge: isr=0, osr=0, isr_cnt=0, osr_cnt=DATA_W (OSR empty); reset overrides any in-progress or stalled request.
REQ-019 After reset, rx_valid=0, tx_ready=0, stall=0, out_data=0.

Configuration
REQ-020 Macro PIO_AUTO_SHIFT_EN SHALL compile in autopush/autopull; without it cfg_*_thresh are unused and only explicit push/pull move data.
REQ-021 With it, after an in_shift making isr_cnt >= cfg_push_thresh, a push SHALL occur on the next penable cycle with blocking semantics, before any new request.
REQ-022 With it, out_shift while osr_cnt >= cfg_pull_thresh SHALL refill from tx_data (tx_ready=1) and shift the fresh data in the same cycle; if !tx_valid, stall=1, no state change.

Structure
REQ-023 Shared package pio_pkg SHALL hold shift-direction constants and the count-width/zero-means-full conversion function.
REQ-024 ISR and OSR SHALL each be an instance of one sub-module pio_shift_reg (data, counter, direction, load/clear).

Verification
REQ-025 DATA_W=32, left ISR, in_shift count=8 data=0xA5 four times, push with rx_ready -> rx_data=0xA5A5A5A5, isr_cnt=0.
REQ-026 Pull tx_data=0x12345678, out_shift right count=4 twice -> out_data 0x8 then 0x7, osr_cnt=8.
REQ-027 Blocking push with rx_ready=0 for 3 cycles -> stall=1 for 3 cycles, ISR unchanged, transfer on cycle 4.
REQ-028 Non-blocking pull, tx_valid=0, pull_fallback=0xDEADBEEF -> osr=0xDEADBEEF, stall=0.
REQ-029 PIO_AUTO_SHIFT_EN, pull_thresh=0 (32), first out_shift count=0 after reset with tx_valid=0 then 1 -> stall one cycle, then out_data=tx_data.
REQ-030 Reset asserted during stalled push -> stall=0, isr=0, osr_cnt=32 next cycle.
